seg7_scan_ctrl: RTL and testbench

Parametrised, time-multiplexed driver for the common-anode 7-segment banks on the board (4 digits on Basys3). It accepts a packed hex value with per-digit decimal points and enables, and scans one digit per refresh slot. Anode switches include a blanking interval to prevent ghosting. Leading-zero suppression is optional, and new values are loaded tear-free only at frame boundaries. It sits between the datapath and the top-level pin constraints.

---
 rtl/seg7_scan_ctrl_pkg.sv | 26 ++
 rtl/seg7_scan_ctrl_if.sv | 27 ++
 rtl/seg7_hex_decode.sv | 9 +
 rtl/seg7_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types, constants and helpers for the 7-segment display blocks.
// Segment vectors are {g,f,e,d,c,b,a} and active-low throughout.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } slot_state_e;

  localparam seg_t SEG_OFF = 7'h7F;

  localparam seg_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Datapath-facing bundle of the display scanner: value/control inputs and
// the registered pin-level cathode/anode outputs.
interface seg7_scan_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    blank_lz;
  logic                    load;
  seg_t                    seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output value_in, dp_in, digit_en, blank_lz, load,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  value_in, dp_in, digit_en, blank_lz, load,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with per-slot blanking,
// optional leading-zero suppression and frame-aligned value updates.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);

  localparam int TICK_W = clog2_safe(TICK_DIV);
  localparam int IDX_W  = clog2_safe(NUM_DIGITS);
  localparam int VAL_W  = 4 * NUM_DIGITS;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] BLANK_END = TICK_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  slot_state_e           state_q, state_d;
  logic [VAL_W-1:0]      pend_val_q, pend_val_d;
  logic [VAL_W-1:0]      act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end;
  logic                  frame_wrap;
  logic                  zero_above;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [NUM_DIGITS-1:0] digit_blank;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  seg_t                  cur_seg;

  // Slot timing and digit sequencing
  always_comb begin
    slot_end   = (tick_q == TICK_LAST);
    frame_wrap = slot_end && (idx_q == IDX_LAST);
    tick_d     = slot_end ? '0 : tick_q + 1'b1;
    idx_d      = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    state_d      = (tick_d < BLANK_END) ? ST_BLANK : ST_SHOW;
    frame_done_d = frame_wrap;
  end

  // A load landing on the wrap cycle is forwarded straight into active.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    if (bus.load) begin
      pend_val_d = bus.value_in;
      pend_dp_d  = bus.dp_in;
    end
    if (frame_wrap) begin
      act_val_d = pend_val_d;
      act_dp_d  = pend_dp_d;
    end
  end

  // Digit k is a leading zero when it and every more-significant nibble are 0.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (act_val_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_above;
    end
    digit_blank = ~bus.digit_en | (lz_mask & {NUM_DIGITS{bus.blank_lz}});
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = act_val_q[4*k +: 4];
        cur_dp    = act_dp_q[k];
        cur_blank = digit_blank[k];
      end
    end
  end

  seg7_hex_decode u_dec (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  // Pin drive: anode stays on for a blanked digit so slot brightness is uniform.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    an_d  = '1;
    if (state_q == ST_SHOW) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_d[k] = (idx_q != IDX_W'(k));
      end
      if (!cur_blank) begin
        seg_d = cur_seg;
        dp_d  = ~cur_dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q       <= '0;
      idx_q        <= '0;
      state_q      <= (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: cycle-accurate reference built from elapsed time
// since reset, directed scenarios with literal expectations, then random traffic.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int TD = 4;
  localparam int BC = 1;

  localparam logic [6:0] HEX_M [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk;
  logic rst;
  seg7_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .TICK_DIV     (TD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int ncnt   = 0;

  // Reference state: elapsed cycles since reset plus the two register sets.
  int               t_m;
  logic [4*ND-1:0]  pend_v, act_v;
  logic [ND-1:0]    pend_p, act_p;
  logic [ND-1:0]    e_an;
  logic [6:0]       e_seg;
  logic             e_dp;
  logic             e_fd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  phase, dig;
    bit  blank;
    logic [3:0] nib;
    if (rst) begin
      t_m = 0; pend_v = '0; act_v = '0; pend_p = '0; act_p = '0;
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      phase = t_m % TD;
      dig   = (t_m / TD) % ND;
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
      if (phase >= BC) begin
        e_an  = ~(ND'(1) << dig);
        nib   = 4'((act_v >> (4 * dig)) & 16'hF);
        blank = !bus.digit_en[dig] ||
                (bus.blank_lz && dig > 0 && (act_v >> (4 * dig)) == 0);
        if (!blank) begin
          e_seg = HEX_M[nib];
          e_dp  = !act_p[dig];
        end
      end
      if (bus.load) begin
        pend_v = bus.value_in;
        pend_p = bus.dp_in;
      end
      t_m = t_m + 1;
      if (t_m % (ND * TD) == 0) begin
        act_v = pend_v; act_p = pend_p; e_fd = 1'b1;
      end else begin
        e_fd = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_an",  32'(bus.an),         32'(e_an));
      chk("cyc_seg", 32'(bus.seg),        32'(e_seg));
      chk("cyc_dp",  32'(bus.dp),         32'(e_dp));
      chk("cyc_fd",  32'(bus.frame_done), 32'(e_fd));
    end
  end

  task automatic step_to(input int k);
    while (ncnt < k) begin
      @(negedge clk);
      ncnt++;
    end
  endtask

  task automatic pin(input string name, input logic [3:0] an, input logic [6:0] seg);
    chk({name, "_an"},  32'(bus.an),  32'(an));
    chk({name, "_seg"}, 32'(bus.seg), 32'(seg));
  endtask

  initial begin
    rst = 1'b1;
    bus.load = 1'b0; bus.value_in = '0; bus.dp_in = '0;
    bus.digit_en = 4'hF; bus.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    ncnt = 0;
    pin("reset", 4'hF, 7'h7F);
    chk("reset_dp", 32'(bus.dp), 32'd1);
    chk("reset_fd", 32'(bus.frame_done), 32'd0);

    // Basic scan order with 12AF, dp on digit 2
    rst = 1'b0; bus.load = 1'b1; bus.value_in = 16'h12AF; bus.dp_in = 4'b0100;
    step_to(1);  bus.load = 1'b0;
    step_to(16); chk("wrap1_fd", 32'(bus.frame_done), 32'd1);
    step_to(17); pin("d0_blank", 4'hF, 7'h7F);
    step_to(18); pin("d0_F", 4'hE, 7'h0E);
    step_to(21); pin("d1_blank", 4'hF, 7'h7F);
    step_to(22); pin("d1_A", 4'hD, 7'h08);
    step_to(26); pin("d2_2", 4'hB, 7'h24);
    chk("d2_dp", 32'(bus.dp), 32'd0);
    step_to(30); pin("d3_1", 4'h7, 7'h79);

    // Leading-zero suppression on 0005, then live disable
    step_to(32); bus.load = 1'b1; bus.value_in = 16'h0005; bus.dp_in = '0; bus.blank_lz = 1'b1;
    step_to(33); bus.load = 1'b0;
    step_to(50); pin("lz_d0", 4'hE, 7'h12);
    step_to(54); pin("lz_d1", 4'hD, 7'h7F);
    chk("lz_d1_dp", 32'(bus.dp), 32'd1);
    step_to(62); pin("lz_d3", 4'h7, 7'h7F);
    bus.blank_lz = 1'b0;
    step_to(63); pin("nolz_d3", 4'h7, 7'h40);

    // Mid-frame load at digit 1 is held until the wrap
    step_to(69); bus.load = 1'b1; bus.value_in = 16'hAAAA;
    step_to(70); bus.load = 1'b0;
    pin("mid_d1_old", 4'hD, 7'h40);
    step_to(74); pin("mid_d2_old", 4'hB, 7'h40);
    step_to(79); chk("mid_fd_pre", 32'(bus.frame_done), 32'd0);
    step_to(80); chk("mid_fd", 32'(bus.frame_done), 32'd1);
    step_to(81); chk("mid_fd_post", 32'(bus.frame_done), 32'd0);
    step_to(82); pin("mid_d0_new", 4'hE, 7'h08);

    // Load exactly on the wrap cycle bypasses into active
    step_to(95); bus.load = 1'b1; bus.value_in = 16'h3333;
    step_to(96); bus.load = 1'b0;
    step_to(98); pin("byp_d0", 4'hE, 7'h30);

    // Reset in phase 2 of digit 2's slot
    step_to(106); rst = 1'b1;
    step_to(107);
    pin("rst_mid", 4'hF, 7'h7F);
    chk("rst_mid_fd", 32'(bus.frame_done), 32'd0);
    rst = 1'b0; ncnt = 0;
    step_to(2); pin("rst_d0_zero", 4'hE, 7'h40);

    // Per-digit enables with 8888
    bus.digit_en = 4'b1010; bus.load = 1'b1; bus.value_in = 16'h8888;
    step_to(3); bus.load = 1'b0;
    step_to(18); pin("en_d0", 4'hE, 7'h7F);
    step_to(22); pin("en_d1", 4'hD, 7'h00);
    step_to(26); pin("en_d2", 4'hB, 7'h7F);
    step_to(30); pin("en_d3", 4'h7, 7'h00);

    // Randomized traffic against the reference
    bus.digit_en = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 599) == 0);
      bus.load = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) bus.value_in = 16'($urandom_range(0, 255));
      else                           bus.value_in = 16'($urandom);
      bus.dp_in = 4'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        bus.digit_en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
        bus.blank_lz = 1'($urandom);
      end
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
